// File: rtl/bioz_meas_sequencer.sv
// bioz_meas_sequencer: settle/measure burst sequencer that keeps the BioZ DAC step counter phase-aligned.
// Define BIOZ_SEQ_ALT_STEP_EN to add CfgAltStep, which alternates StepNum between bursts.
module bioz_meas_sequencer (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        Start,
    input  logic        Abort,
    input  logic        CfgStepNum,
    input  logic [7:0]  CfgSettle,
    input  logic [11:0] CfgMeas,
    input  logic [3:0]  CfgRepeat,
    input  logic [3:0]  CfgGap,
`ifdef BIOZ_SEQ_ALT_STEP_EN
    input  logic        CfgAltStep,
`endif
    output logic        CountEnable,
    output logic        StepNum,
    output logic        SigGenResetn,
    output logic        MeasWindow,
    output logic        PeriodTick,
    output logic [3:0]  RepIdx,
    output logic        Busy,
    output logic        Done,
    output logic        Aborted
);
    typedef enum logic [2:0] {IDLE, SETTLE, MEAS, GAP, DONE} state_t;
    state_t state;
    logic [4:0] phase;
    logic [11:0] pcnt;
    logic [3:0] gcnt;
    logic [7:0] settle;
    logic [11:0] meas;
    logic [3:0] reps;
    logic [3:0] gap;
    logic [4:0] plast;
    logic last, settle_end, meas_end, gap_end, next_step;
    assign plast = StepNum ? 5'd15 : 5'd31;
    assign last = phase == plast;
    assign settle_end = pcnt == {4'd0, settle} - 12'd1;
    assign meas_end = pcnt == ((meas == 12'd0) ? 12'd0 : meas - 12'd1);
    assign gap_end = gcnt == ((gap == 4'd0) ? 4'd0 : gap - 4'd1);
`ifdef BIOZ_SEQ_ALT_STEP_EN
    logic alt;
    assign next_step = StepNum ^ alt;
`else
    assign next_step = StepNum;
`endif

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            phase <= 5'd0;
            pcnt <= 12'd0;
            gcnt <= 4'd0;
            settle <= 8'd0;
            meas <= 12'd0;
            reps <= 4'd0;
            gap <= 4'd0;
`ifdef BIOZ_SEQ_ALT_STEP_EN
            alt <= 1'b0;
`endif
            CountEnable <= 1'b0;
            StepNum <= 1'b0;
            SigGenResetn <= 1'b0;
            MeasWindow <= 1'b0;
            PeriodTick <= 1'b0;
            RepIdx <= 4'd0;
            Busy <= 1'b0;
            Done <= 1'b0;
            Aborted <= 1'b0;
        end else begin
            Done <= 1'b0;
            Aborted <= 1'b0;
            PeriodTick <= 1'b0;
            case (state)
                IDLE: if (Start && !Abort) begin
                    settle <= CfgSettle;
                    meas <= CfgMeas;
                    reps <= CfgRepeat;
                    gap <= CfgGap;
`ifdef BIOZ_SEQ_ALT_STEP_EN
                    alt <= CfgAltStep;
`endif
                    state <= (CfgSettle == 8'd0) ? MEAS : SETTLE;
                    MeasWindow <= CfgSettle == 8'd0;
                    StepNum <= CfgStepNum;
                    CountEnable <= 1'b1;
                    SigGenResetn <= 1'b1;
                    Busy <= 1'b1;
                    RepIdx <= 4'd0;
                    phase <= 5'd0;
                    pcnt <= 12'd0;
                end
                SETTLE, MEAS, GAP: if (Abort) begin
                    state <= IDLE;
                    CountEnable <= 1'b0;
                    StepNum <= 1'b0;
                    SigGenResetn <= 1'b0;
                    MeasWindow <= 1'b0;
                    RepIdx <= 4'd0;
                    Busy <= 1'b0;
                    Aborted <= 1'b1;
                end else if (state == GAP) begin
                    gcnt <= gcnt + 4'd1;
                    if (gap_end) begin
                        state <= (settle == 8'd0) ? MEAS : SETTLE;
                        MeasWindow <= settle == 8'd0;
                        StepNum <= next_step;
                        CountEnable <= 1'b1;
                        SigGenResetn <= 1'b1;
                        RepIdx <= RepIdx + 4'd1;
                        phase <= 5'd0;
                        pcnt <= 12'd0;
                    end
                end else if (!last) begin
                    phase <= phase + 5'd1;
                    PeriodTick <= (state == MEAS) && (phase + 5'd1 == plast);
                end else begin
                    // period boundary: the DAC counter wraps to step 0 together with phase
                    phase <= 5'd0;
                    pcnt <= pcnt + 12'd1;
                    if (state == SETTLE && settle_end) begin
                        state <= MEAS;
                        MeasWindow <= 1'b1;
                        pcnt <= 12'd0;
                    end else if (state == MEAS && meas_end) begin
                        state <= (RepIdx == reps) ? DONE : GAP;
                        Done <= RepIdx == reps;
                        CountEnable <= 1'b0;
                        SigGenResetn <= 1'b0;
                        MeasWindow <= 1'b0;
                        pcnt <= 12'd0;
                        gcnt <= 4'd0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy <= 1'b0;
                    StepNum <= 1'b0;
                    RepIdx <= 4'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bioz_meas_sequencer.sv
// tb_bioz_meas_sequencer: randomized and directed checks against a per-cycle trace model.
module tb_bioz_meas_sequencer;
    logic Clk = 1'b0;
    logic Resetn = 1'b0;
    logic Start = 1'b0;
    logic Abort = 1'b0;
    logic CfgStepNum = 1'b0;
    logic [7:0] CfgSettle = 8'd0;
    logic [11:0] CfgMeas = 12'd0;
    logic [3:0] CfgRepeat = 4'd0;
    logic [3:0] CfgGap = 4'd0;
`ifdef BIOZ_SEQ_ALT_STEP_EN
    logic CfgAltStep = 1'b0;
`endif
    logic CountEnable, StepNum, SigGenResetn, MeasWindow, PeriodTick, Busy, Done, Aborted;
    logic [3:0] RepIdx;
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic ce, sn, sr, mw, pt;
        logic [3:0] ri;
        logic busy, done, ab;
    } out_t;
    out_t exp_q[$];

    bioz_meas_sequencer dut (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .Abort(Abort),
        .CfgStepNum(CfgStepNum), .CfgSettle(CfgSettle), .CfgMeas(CfgMeas),
        .CfgRepeat(CfgRepeat), .CfgGap(CfgGap),
`ifdef BIOZ_SEQ_ALT_STEP_EN
        .CfgAltStep(CfgAltStep),
`endif
        .CountEnable(CountEnable), .StepNum(StepNum), .SigGenResetn(SigGenResetn),
        .MeasWindow(MeasWindow), .PeriodTick(PeriodTick), .RepIdx(RepIdx),
        .Busy(Busy), .Done(Done), .Aborted(Aborted)
    );

    always #5 Clk = ~Clk;

    function automatic out_t mk(logic ce, logic sn, logic sr, logic mw, logic pt,
                                logic [3:0] ri, logic busy, logic done, logic ab);
        out_t o;
        o.ce = ce; o.sn = sn; o.sr = sr; o.mw = mw; o.pt = pt;
        o.ri = ri; o.busy = busy; o.done = done; o.ab = ab;
        return o;
    endfunction

    function automatic out_t obs();
        return mk(CountEnable, StepNum, SigGenResetn, MeasWindow, PeriodTick, RepIdx, Busy, Done, Aborted);
    endfunction

    // Expected outputs for cycles 1..N after Start, built burst by burst from the period arithmetic.
    task automatic build_model(input logic step, input int settle, input int meas, input int rep,
                               input int gap, input logic alt, input int abort_at);
        int l, meff, geff;
        logic s, t;
        logic [3:0] bi;
        exp_q.delete();
        meff = (meas == 0) ? 1 : meas;
        geff = (gap == 0) ? 1 : gap;
        for (int b = 0; b <= rep; b++) begin
            bi = 4'(b);
            s = step ^ (alt & bi[0]);
            l = s ? 16 : 32;
            for (int i = 0; i < settle * l; i++)
                exp_q.push_back(mk(1'b1, s, 1'b1, 1'b0, 1'b0, bi, 1'b1, 1'b0, 1'b0));
            for (int i = 0; i < meff * l; i++) begin
                t = (i % l) == l - 1;
                exp_q.push_back(mk(1'b1, s, 1'b1, 1'b1, t, bi, 1'b1, 1'b0, 1'b0));
            end
            if (b < rep)
                for (int i = 0; i < geff; i++)
                    exp_q.push_back(mk(1'b0, s, 1'b0, 1'b0, 1'b0, bi, 1'b1, 1'b0, 1'b0));
            else
                exp_q.push_back(mk(1'b0, s, 1'b0, 1'b0, 1'b0, bi, 1'b1, 1'b1, 1'b0));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        if (abort_at > 0 && abort_at <= exp_q.size() && exp_q[abort_at-1].busy && !exp_q[abort_at-1].done) begin
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // Called at a negedge with the DUT idle; Start is driven during cycle 0.
    task automatic run_seq(input string name, input logic step, input int settle, input int meas,
                           input int rep, input int gap, input logic alt, input int abort_at, input bit disturb);
        out_t o;
        build_model(step, settle, meas, rep, gap, alt, abort_at);
        CfgStepNum = step;
        CfgSettle = 8'(settle);
        CfgMeas = 12'(meas);
        CfgRepeat = 4'(rep);
        CfgGap = 4'(gap);
`ifdef BIOZ_SEQ_ALT_STEP_EN
        CfgAltStep = alt;
`endif
        Start = 1'b1;
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge Clk);
            o = obs();
            checks++;
            if (o !== exp_q[c-1]) begin
                errors++;
                $display("FAIL %s cycle %0d {ce,sn,sr,mw,pt,ri,busy,done,ab}: got %b expected %b",
                         name, c, o, exp_q[c-1]);
            end
            Start = disturb && c == 50 && exp_q[c-1].busy;
            Abort = c == abort_at;
            if (disturb && c == 50) begin
                CfgStepNum = ~step;
                CfgSettle = 8'($urandom_range(0, 5));
                CfgMeas = 12'($urandom_range(0, 5));
                CfgRepeat = 4'($urandom_range(0, 5));
                CfgGap = 4'($urandom_range(0, 9));
            end
        end
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 0", obs());
        end
        Resetn = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_release: got %b expected 0", obs());
        end
    endtask

    task automatic test_single_burst();
        run_seq("single32", 1'b0, 1, 2, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_seq("repeat16", 1'b1, 0, 1, 1, 3, 1'b0, 0, 1'b0);
    endtask

    task automatic test_abort();
        run_seq("abort_meas", 1'b0, 1, 2, 0, 0, 1'b0, 40, 1'b0);
        run_seq("abort_settle", 1'b0, 1, 2, 0, 0, 1'b0, 5, 1'b0);
        run_seq("abort_gap", 1'b1, 0, 1, 1, 3, 1'b0, 18, 1'b0);
        run_seq("abort_in_done", 1'b0, 1, 2, 0, 0, 1'b0, 97, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_seq("ignored_start", 1'b0, 1, 2, 0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_zero_clamp();
        run_seq("clamp", 1'b1, 0, 0, 1, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_start_abort();
        Start = 1'b1;
        Abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (obs() !== '0) begin
                errors++;
                $display("FAIL start_abort cycle %0d: got %b expected 0", i + 1, obs());
            end
        end
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic test_async_reset();
        CfgStepNum = 1'b0;
        CfgSettle = 8'd1;
        CfgMeas = 12'd2;
        CfgRepeat = 4'd0;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (20) @(negedge Clk);
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_busy: got %b expected 1", Busy);
        end
        #2 Resetn = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0", obs());
        end
        @(negedge Clk);
        Resetn = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL async_after: got %b expected 0", obs());
        end
    endtask

`ifdef BIOZ_SEQ_ALT_STEP_EN
    task automatic test_alt_step();
        run_seq("alt_step", 1'b0, 0, 1, 1, 0, 1'b1, 0, 1'b0);
        run_seq("alt_step3", 1'b1, 1, 1, 2, 2, 1'b1, 0, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic step, alt;
        int ab;
        for (int n = 0; n < 8; n++) begin
            step = 1'($urandom_range(0, 1));
            alt = 1'b0;
`ifdef BIOZ_SEQ_ALT_STEP_EN
            alt = 1'($urandom_range(0, 1));
`endif
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 200)) : 0;
            run_seq("random", step, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 5)), alt, ab, ab == 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_abort();
        test_ignored_start();
        test_zero_clamp();
        test_start_abort();
        test_async_reset();
`ifdef BIOZ_SEQ_ALT_STEP_EN
        test_alt_step();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bioz_meas_sequencer.md
# bioz_meas_sequencer

Measurement sequencer for the BioZ signal generator. It drives the DAC controller's `CountEnable`, `StepNum` and counter reset so each injection burst starts phase-aligned at DAC step 0. Each burst runs a settle interval, then a measurement window of whole excitation periods. Repeated bursts are separated by an idle gap, and the block gives a Start/Done handshake to the system controller.

## Interface
- Parameters: none; all widths are fixed.
- `Clk`  in  1  same clock that drives the DAC controller's `Clk`.
- `Resetn`  in  1  reset; asynchronous, active-low.
- `Start`  in  1  begin a sequence; sampled only in IDLE.
- `Abort`  in  1  terminate the sequence; effective in SETTLE, MEAS and GAP.
- `CfgStepNum`  in  1  0 = 32-step period, 1 = 16-step period.
- `CfgSettle`  in  8  number of settle periods; 0 skips SETTLE.
- `CfgMeas`  in  12  number of measurement periods; 0 is treated as 1.
- `CfgRepeat`  in  4  number of bursts is CfgRepeat+1.
- `CfgGap`  in  4  gap length in cycles between bursts; 0 is treated as 1.
- `CfgAltStep`  in  1  present only with `BIOZ_SEQ_ALT_STEP_EN`.
- `CountEnable`  out  1  drives the DAC controller's `CountEnable`.
- `StepNum`  out  1  drives the DAC controller's `StepNum`.
- `SigGenResetn`  out  1  drives the DAC controller's `Resetn` (ANDed externally with the system reset).
- `MeasWindow`  out  1  high during MEAS.
- `PeriodTick`  out  1  one-cycle pulse on the last cycle of each measurement period.
- `RepIdx`  out  4  index of the current burst.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse when the sequence completes normally.
- `Aborted`  out  1  one-cycle pulse when the sequence is aborted.

## Operation
- **Registered outputs and reset state**
  - All outputs are registered.
  - Reset values: every output is 0, including `SigGenResetn`, so the DAC is held at step 0.
- **States:** IDLE, SETTLE, MEAS, GAP, DONE.
- **Configuration latch**
  - On `Start` in IDLE, all Cfg* inputs are latched.
  - Cfg* changes after that point have no effect until the next Start.
  - `Start` in any other state is ignored.
- **Period length:** L = 32 when the latched StepNum is 0, else L = 16.
- **Phase counter**
  - 5-bit counter, cleared to 0 when a burst is entered.
  - Increments every cycle in SETTLE and MEAS.
  - Marks end of period when phase == L-1, then wraps to 0.
  - It mirrors the DAC controller's step count exactly.
- **Transitions**
  - IDLE→SETTLE on Start, or IDLE→MEAS if CfgSettle == 0.
  - SETTLE→MEAS after CfgSettle full periods.
  - MEAS lasts max(CfgMeas,1) full periods.
  - At the end of MEAS: go to GAP if bursts remain, else go to DONE.
  - GAP→SETTLE (or MEAS when settle is 0) after max(CfgGap,1) cycles.
  - DONE→IDLE after one cycle.
- **Output values per state**
  - SETTLE and MEAS: `CountEnable`=1, `SigGenResetn`=1.
  - IDLE, GAP and DONE: both 0, so the DAC outputs 0 V and its counter is cleared for the next aligned start.
- **RepIdx:** 0 in the first burst; increments on the first cycle of each subsequent burst; returns to 0 in IDLE.
- **Counter widths:** settle/measure period counter is 12 bits and never wraps within a legal configuration.
- **Abort**
  - In SETTLE, MEAS or GAP: the next cycle is IDLE, `Aborted`=1 for one cycle, and all other outputs take their reset values. `Done` is not pulsed.
  - Abort in IDLE or DONE is ignored.
  - If Start and Abort are asserted together in IDLE, the block stays in IDLE with no pulse.
- **Reset mid-operation:** forces IDLE and reset values immediately (asynchronously).

## Timing
- **Start latency:** Start sampled at cycle t; at cycle t+1 the block is in the first burst state with `CountEnable`, `SigGenResetn` and `StepNum` valid. The DAC step-0 code is held during t+1.
- **MEAS timing**
  - MEAS begins at cycle t+1+CfgSettle·L.
  - `PeriodTick` asserts on MEAS cycles where phase == L-1.
- **Inter-burst spacing:** the first burst cycle of the next burst follows the last MEAS cycle by max(CfgGap,1)+1 cycles.
- **Completion:** `Done` is asserted on the cycle after the final MEAS cycle; `Busy` falls one cycle later.

## Configuration
- **`BIOZ_SEQ_ALT_STEP_EN` defined:**
  - `CfgAltStep` port exists and is latched at Start.
  - When the latched value is 1, `StepNum` toggles at the start of every burst after the first, and L follows it.
- **Not defined:**
  - `CfgAltStep` port is absent.
  - `StepNum` stays at the latched `CfgStepNum` for the whole sequence.

## Test plan
- **32-step single burst:** StepNum=0, Settle=1, Meas=2, Repeat=0, Start at cycle 0 → SETTLE cycles 1–32; MeasWindow cycles 33–96; PeriodTick at cycles 64 and 96; Done at 97; Busy high cycles 1–97.
- **16-step repeated bursts:** StepNum=1, Settle=0, Meas=1, Repeat=1, Gap=3, Start at 0 → MEAS 1–16 (tick at 16); GAP 17–19 with CountEnable=0 and SigGenResetn=0; MEAS 20–35 with RepIdx=1 (tick at 35); Done at 36.
- **Abort:** Abort at cycle 40 in the first scenario → cycle 41: IDLE, Aborted=1, CountEnable=0, SigGenResetn=0; Done is never asserted.
- **Ignored Start / config changes:** Start pulsed at cycle 50 and Cfg* changed mid-run during the first scenario → timing identical to the first scenario.
- **Zero-value clamping:** Meas=0 and Gap=0, Repeat=1, StepNum=1, Settle=0 → each MEAS lasts 16 cycles and the gap lasts 1 cycle.
- **Alternating step count (macro on):** StepNum=0, AltStep=1, Settle=0, Meas=1, Repeat=1 → first burst L=32, second burst StepNum=1 and L=16.
